// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - joint TLB array with TLBR/TLBP/TLBWI/TLBWR controller
// and a combinational MMU lookup port; TLBP scans PROBE_W entries per cycle.
module tlb_ctrl #(
   parameter int TLBNUM  = 16,
   parameter int PROBE_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_i,
   input  logic [1:0]  op_code_i,
   output logic        op_ready_o,
   input  logic        flush_i,
   input  logic [31:0] cp0_entryHi_i,
   input  logic [31:0] cp0_pageMask_i,
   input  logic [31:0] cp0_entryLo0_i,
   input  logic [31:0] cp0_entryLo1_i,
   input  logic [31:0] cp0_index_i,
   input  logic [31:0] cp0_random_i,
   output logic [2:0]  tlb_type_o,
   output logic        busy_o,
   output logic [31:0] tlb_entryHi_o,
   output logic [31:0] tlb_pageMask_o,
   output logic [31:0] tlb_entryLo0_o,
   output logic [31:0] tlb_entryLo1_o,
   output logic [31:0] tlb_index_o,
   input  logic [18:0] lk_vpn2_i,
   input  logic [7:0]  lk_asid_i,
   output logic        lk_hit_o,
   output logic [4:0]  lk_idx_o
);
   localparam int IW   = $clog2(TLBNUM);
   localparam int NGRP = TLBNUM / PROBE_W;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic [11:0] mask;
      logic        g;
      logic [24:0] lo0;   // {PFN, C, D, V}
      logic [24:0] lo1;
   } entry_t;

   typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

   state_t        state_q, state_d;
   entry_t        tlb_q [TLBNUM];
   entry_t        tlb_d [TLBNUM];
   logic [GW-1:0] grp_q, grp_d;
   logic          hit_q, hit_d;
   logic [IW-1:0] hit_idx_q, hit_idx_d;
   logic [18:0]   p_vpn2_q, p_vpn2_d;
   logic [7:0]    p_asid_q, p_asid_d;
   logic [2:0]    type_q, type_d;
   logic [31:0]   hi_q, hi_d, pm_q, pm_d, lo0_q, lo0_d, lo1_q, lo1_d, idx_q, idx_d;

   logic          accept;
   logic [IW-1:0] sel_idx;
   entry_t        wr_ent, rd_ent;
   logic          grp_hit;
   logic [IW-1:0] grp_idx;
   logic          unused_bits;

   function automatic logic ent_match(input entry_t e, input logic [18:0] vpn2,
                                      input logic [7:0] asid);
      return ((((e.vpn2 ^ vpn2) & ~{7'b0, e.mask}) == 19'b0) && (e.g || (e.asid == asid)));
   endfunction

   assign op_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign accept     = op_valid_i & op_ready_o & ~flush_i;
   assign sel_idx    = (op_code_i == 2'b11) ? cp0_random_i[IW-1:0] : cp0_index_i[IW-1:0];
   assign rd_ent     = tlb_q[sel_idx];

   assign wr_ent.vpn2 = cp0_entryHi_i[31:13];
   assign wr_ent.asid = cp0_entryHi_i[7:0];
   assign wr_ent.mask = cp0_pageMask_i[24:13];
   assign wr_ent.g    = cp0_entryLo0_i[0] & cp0_entryLo1_i[0];
   assign wr_ent.lo0  = cp0_entryLo0_i[25:1];
   assign wr_ent.lo1  = cp0_entryLo1_i[25:1];

   assign unused_bits = ^{cp0_entryHi_i[12:8], cp0_pageMask_i[31:25], cp0_pageMask_i[12:0],
                          cp0_entryLo0_i[31:26], cp0_entryLo1_i[31:26],
                          cp0_index_i[31:IW], cp0_random_i[31:IW]};

   // Descending scan so the lowest matching index wins.
   always_comb begin
      grp_hit = 1'b0;
      grp_idx = '0;
      for (int j = PROBE_W - 1; j >= 0; j--) begin
         if (ent_match(tlb_q[int'(grp_q) * PROBE_W + j], p_vpn2_q, p_asid_q)) begin
            grp_hit = 1'b1;
            grp_idx = IW'(int'(grp_q) * PROBE_W + j);
         end
      end
   end

   always_comb begin
      lk_hit_o = 1'b0;
      lk_idx_o = 5'd0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (ent_match(tlb_q[i], lk_vpn2_i, lk_asid_i)) begin
            lk_hit_o = 1'b1;
            lk_idx_o = 5'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      tlb_d     = tlb_q;
      grp_d     = grp_q;
      hit_d     = hit_q;
      hit_idx_d = hit_idx_q;
      p_vpn2_d  = p_vpn2_q;
      p_asid_d  = p_asid_q;
      type_d    = type_q;
      hi_d      = hi_q;
      pm_d      = pm_q;
      lo0_d     = lo0_q;
      lo1_d     = lo1_q;
      idx_d     = idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_code_i)
                  2'b00: begin
                     hi_d    = {rd_ent.vpn2, 5'b0, rd_ent.asid};
                     pm_d    = {7'b0, rd_ent.mask, 13'b0};
                     lo0_d   = {6'b0, rd_ent.lo0, rd_ent.g};
                     lo1_d   = {6'b0, rd_ent.lo1, rd_ent.g};
                     type_d  = 3'b010;
                     state_d = DONE;
                  end
                  2'b01: begin
                     p_vpn2_d  = cp0_entryHi_i[31:13];
                     p_asid_d  = cp0_entryHi_i[7:0];
                     grp_d     = '0;
                     hit_d     = 1'b0;
                     hit_idx_d = '0;
                     state_d   = PROBE;
                  end
                  default: begin
                     tlb_d[sel_idx] = wr_ent;
                     type_d         = 3'b000;
                     state_d        = DONE;
                  end
               endcase
            end
         end
         PROBE: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               if (!hit_q && grp_hit) begin
                  hit_d     = 1'b1;
                  hit_idx_d = grp_idx;
               end
               if (grp_q == GW'(NGRP - 1)) begin
                  type_d  = 3'b001;
                  state_d = DONE;
                  if (hit_q || grp_hit)
                     idx_d = {{(32 - IW){1'b0}}, (hit_q ? hit_idx_q : grp_idx)};
                  else
                     idx_d = 32'h8000_0000;
               end else begin
                  grp_d = grp_q + GW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
         grp_q     <= '0;
         hit_q     <= 1'b0;
         hit_idx_q <= '0;
         p_vpn2_q  <= '0;
         p_asid_q  <= '0;
         type_q    <= 3'b000;
         hi_q      <= '0;
         pm_q      <= '0;
         lo0_q     <= '0;
         lo1_q     <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= tlb_d[i];
         grp_q     <= grp_d;
         hit_q     <= hit_d;
         hit_idx_q <= hit_idx_d;
         p_vpn2_q  <= p_vpn2_d;
         p_asid_q  <= p_asid_d;
         type_q    <= type_d;
         hi_q      <= hi_d;
         pm_q      <= pm_d;
         lo0_q     <= lo0_d;
         lo1_q     <= lo1_d;
         idx_q     <= idx_d;
      end
   end

   // A flush landing in DONE swallows the result pulse.
   assign tlb_type_o     = ((state_q == DONE) && !flush_i) ? type_q : 3'b000;
   assign tlb_entryHi_o  = hi_q;
   assign tlb_pageMask_o = pm_q;
   assign tlb_entryLo0_o = lo0_q;
   assign tlb_entryLo1_o = lo1_q;
   assign tlb_index_o    = idx_q;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb/tb_tlb_ctrl.sv - scoreboard bench for tlb_ctrl
module tb_tlb_ctrl;
   localparam int NGRP = 16 / 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic [1:0]  op_code = 2'b00;
   logic        flush = 1'b0;
   logic [31:0] cp0_hi = '0, cp0_pm = '0, cp0_lo0 = '0, cp0_lo1 = '0;
   logic [31:0] cp0_index = '0, cp0_random = '0;
   logic [18:0] lk_vpn2 = '0;
   logic [7:0]  lk_asid = '0;
   logic        op_ready_o, busy_o, lk_hit_o;
   logic [2:0]  tlb_type_o;
   logic [31:0] tlb_entryHi_o, tlb_pageMask_o, tlb_entryLo0_o, tlb_entryLo1_o, tlb_index_o;
   logic [4:0]  lk_idx_o;

   tlb_ctrl #(.TLBNUM(16), .PROBE_W(4)) dut (
      .clk(clk), .rst(rst),
      .op_valid_i(op_valid), .op_code_i(op_code), .op_ready_o(op_ready_o), .flush_i(flush),
      .cp0_entryHi_i(cp0_hi), .cp0_pageMask_i(cp0_pm),
      .cp0_entryLo0_i(cp0_lo0), .cp0_entryLo1_i(cp0_lo1),
      .cp0_index_i(cp0_index), .cp0_random_i(cp0_random),
      .tlb_type_o(tlb_type_o), .busy_o(busy_o),
      .tlb_entryHi_o(tlb_entryHi_o), .tlb_pageMask_o(tlb_pageMask_o),
      .tlb_entryLo0_o(tlb_entryLo0_o), .tlb_entryLo1_o(tlb_entryLo1_o),
      .tlb_index_o(tlb_index_o),
      .lk_vpn2_i(lk_vpn2), .lk_asid_i(lk_asid), .lk_hit_o(lk_hit_o), .lk_idx_o(lk_idx_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  t;
      int          cyc;
      logic [31:0] hi, pm, lo0, lo1, idx;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && tlb_type_o !== 3'b000) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'(tlb_type_o), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("pulse_type", 32'(tlb_type_o), 32'(mon_e.t));
            chk("pulse_cycle", cyc, mon_e.cyc);
            if (mon_e.t == 3'b010) begin
               chk("tlbr_entryHi", tlb_entryHi_o, mon_e.hi);
               chk("tlbr_pageMask", tlb_pageMask_o, mon_e.pm);
               chk("tlbr_entryLo0", tlb_entryLo0_o, mon_e.lo0);
               chk("tlbr_entryLo1", tlb_entryLo1_o, mon_e.lo1);
            end else begin
               chk("tlbp_index", tlb_index_o, mon_e.idx);
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (op_ready_o !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) chk("ready_timeout", 32'(op_ready_o), 32'd1);
   endtask

   task automatic issue(input logic [1:0] code, output int acc);
      wait_ready();
      op_valid = 1'b1;
      op_code  = code;
      @(posedge clk);
      #1;
      acc      = cyc;
      op_valid = 1'b0;
   endtask

   task automatic set_cp0(input logic [31:0] hi, input logic [31:0] pm,
                          input logic [31:0] lo0, input logic [31:0] lo1);
      cp0_hi  = hi;
      cp0_pm  = pm;
      cp0_lo0 = lo0;
      cp0_lo1 = lo1;
   endtask

   task automatic op_w(input logic [31:0] idx);
      int acc;
      cp0_index = idx;
      issue(2'b10, acc);
      wait_ready();
   endtask

   task automatic op_r(input logic [31:0] idx, input logic [31:0] ehi, input logic [31:0] epm,
                       input logic [31:0] elo0, input logic [31:0] elo1);
      int acc;
      cp0_index = idx;
      issue(2'b00, acc);
      sb.push_back('{3'b010, acc, ehi, epm, elo0, elo1, 32'h0});
      wait_ready();
   endtask

   task automatic op_p(input logic [31:0] hi, input logic [31:0] eidx);
      int acc;
      cp0_hi = hi;
      issue(2'b01, acc);
      sb.push_back('{3'b001, acc + NGRP, 32'h0, 32'h0, 32'h0, 32'h0, eidx});
      wait_ready();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int acc;
      logic [31:0] va;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_type", 32'(tlb_type_o), 32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_index", tlb_index_o, 32'd0);
      chk("reset_entryHi", tlb_entryHi_o, 32'd0);
      rst = 1'b1;

      // Reset asserted in the middle of a probe.
      cp0_hi = 32'h1234_6012;
      issue(2'b01, acc);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midprobe_rst_type", 32'(tlb_type_o), 32'd0);
      chk("midprobe_rst_busy", 32'(busy_o), 32'd0);
      chk("midprobe_rst_index", tlb_index_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("post_rst_ready", 32'(op_ready_o), 32'd1);
      repeat (8) @(posedge clk);
      #1;

      op_r(3, 32'h0, 32'h0, 32'h0, 32'h0);

      set_cp0(32'h1234_6012, 32'h0, 32'h0000_0107, 32'h0000_0146);
      op_w(5);
      op_r(5, 32'h1234_6012, 32'h0, 32'h0000_0106, 32'h0000_0146);

      op_p(32'h1234_6012, 32'd5);
      op_p(32'h1234_600D, 32'h8000_0000);

      set_cp0(32'h1234_6012, 32'h0, 32'h0000_0107, 32'h0000_0147);
      op_w(5);
      op_p(32'h1234_600D, 32'd5);

      // Identical entries at 9 and 2: lowest index must win.
      set_cp0(32'h0ABC_E033, 32'h0, 32'h0000_1006, 32'h0000_2006);
      op_w(9);
      op_w(2);
      op_p(32'h0ABC_E033, 32'd2);
      va = 32'h0ABC_E033;
      lk_vpn2 = va[31:13];
      lk_asid = 8'h33;
      #1;
      chk("lk_multi_hit", 32'(lk_hit_o), 32'd1);
      chk("lk_multi_idx", 32'(lk_idx_o), 32'd2);

      // TLBWR to entry 11 via Random; lookup sees it only after the edge.
      va = 32'h7654_2044;
      lk_vpn2 = va[31:13];
      lk_asid = 8'h44;
      #1;
      chk("lk_miss_hit", 32'(lk_hit_o), 32'd0);
      chk("lk_miss_idx", 32'(lk_idx_o), 32'd0);
      set_cp0(32'h7654_2044, 32'h0, 32'h0000_0306, 32'h0000_0506);
      cp0_random = 32'h0000_001B;
      cp0_index  = 32'd5;
      wait_ready();
      op_valid = 1'b1;
      op_code  = 2'b11;
      #1;
      chk("tlbwr_write_cycle_hit", 32'(lk_hit_o), 32'd0);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      chk("tlbwr_next_hit", 32'(lk_hit_o), 32'd1);
      chk("tlbwr_next_idx", 32'(lk_idx_o), 32'd11);
      wait_ready();
      op_p(32'h1234_6012, 32'd5);

      // Flush during PROBE cycle 2.
      cp0_hi = 32'h0ABC_E033;
      issue(2'b01, acc);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_probe_busy", 32'(busy_o), 32'd0);
      chk("flush_probe_ready", 32'(op_ready_o), 32'd1);
      chk("flush_probe_index", tlb_index_o, 32'd5);
      repeat (8) @(posedge clk);
      #1;

      // Flush together with a request blocks acceptance.
      cp0_index = 32'd9;
      op_valid  = 1'b1;
      op_code   = 2'b00;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_req_busy", 32'(busy_o), 32'd0);
      chk("flush_req_entryHi", tlb_entryHi_o, 32'h1234_6012);
      repeat (4) @(posedge clk);
      #1;

      // Flush in DONE: TLBR still commits results but the pulse is suppressed.
      cp0_index = 32'd9;
      issue(2'b00, acc);
      flush = 1'b1;
      #1;
      chk("done_flush_type", 32'(tlb_type_o), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("done_flush_entryHi", tlb_entryHi_o, 32'h0ABC_E033);
      chk("done_flush_entryLo0", tlb_entryLo0_o, 32'h0000_1006);
      wait_ready();
      repeat (4) @(posedge clk);
      #1;

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
